regfile_pairs_gen: RTL and testbench

//  Parametrised successor of the fixed A/L/H/E/D/C/B register set: NREGS registers of WIDTH

---
 rtl/regfile_pairs_pkg.sv | 21 ++
 rtl/regfile_pairs_idu.sv | 40 ++++
 rtl/regfile_pairs_gen.sv | 132 +++++++++++++
 tb/tb_regfile_pairs_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pairs_pkg.sv
// Shared types and width helpers for the paired register file.
package regfile_pairs_pkg;

    // Which writer owns a register's next value this cycle, highest priority first.
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_IDU,
        SRC_PW,
        SRC_WA,
        SRC_WB
    } src_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned pair_w(input int unsigned n);
        return idx_w(n / 2);
    endfunction

endpackage

// File: rtl/regfile_pairs_idu.sv
// Pair increment/decrement unit: combinational result for the file, registered status.
module regfile_pairs_idu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 nres,
    input  logic                 op_valid,
    input  logic                 op_inc,
    input  logic [2*WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0]   res_c,
    output logic [2*WIDTH-1:0]   idu_q,
    output logic                 idu_wrap,
    output logic                 idu_zero
);

    localparam int unsigned DW = 2 * WIDTH;

    logic wrap_c;

    always_comb begin
        res_c  = op_inc ? (operand + DW'(1)) : (operand - DW'(1));
        wrap_c = op_inc ? (&operand) : ~(|operand);
    end

    // Status only moves on a valid op; wrap is a single-cycle pulse.
    always_ff @(posedge CLK or negedge nres) begin
        if (!nres) begin
            idu_q    <= '0;
            idu_wrap <= 1'b0;
            idu_zero <= 1'b0;
        end else if (op_valid) begin
            idu_q    <= res_c;
            idu_wrap <= wrap_c;
            idu_zero <= (res_c == '0);
        end else begin
            idu_wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_pairs_gen.sv
// Parametrised register file with two byte write ports, a pair write, a pair
// inc/dec unit and NRD combinational read ports.
module regfile_pairs_gen
    import regfile_pairs_pkg::*;
#(
    parameter int unsigned    WIDTH     = 8,
    parameter int unsigned    NREGS     = 8,
    parameter int unsigned    NRD       = 4,
    parameter bit             BYPASS    = 1'b0,
    parameter bit             INV_OUT   = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned   IW        = idx_w(NREGS),
    localparam int unsigned   PW        = pair_w(NREGS)
) (
    input  logic                   CLK,
    input  logic                   nres,
    input  logic                   wa_en,
    input  logic [IW-1:0]          wa_idx,
    input  logic [WIDTH-1:0]       wa_d,
    input  logic                   wb_en,
    input  logic [IW-1:0]          wb_idx,
    input  logic [WIDTH-1:0]       wb_d,
    input  logic                   pw_en,
    input  logic [PW-1:0]          pw_idx,
    input  logic [2*WIDTH-1:0]     pw_d,
    input  logic                   inc_en,
    input  logic                   dec_en,
    input  logic [PW-1:0]          idu_idx,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*IW-1:0]      rd_idx,
    output logic [NRD*WIDTH-1:0]   rd_d,
    output logic [2*WIDTH-1:0]     idu_q,
    output logic                   idu_wrap,
    output logic                   idu_zero,
    output logic                   wr_conf
);

    localparam int unsigned NP = NREGS / 2;
    localparam int unsigned DW = 2 * WIDTH;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] nxt  [NREGS];
    logic [DW-1:0]    idu_opnd;
    logic [DW-1:0]    idu_res;
    logic             idu_ok;
    logic             conf_c;

    // IDU operand is always the pre-edge pair value.
    always_comb begin
        idu_opnd = '0;
        for (int p = 0; p < NP; p++) begin
            if (idu_idx == PW'(p)) idu_opnd = {regs[2*p+1], regs[2*p]};
        end
        idu_ok = (inc_en ^ dec_en) && (32'(idu_idx) < NP);
    end

    regfile_pairs_idu #(.WIDTH(WIDTH)) u_idu (
        .CLK      (CLK),
        .nres     (nres),
        .op_valid (idu_ok),
        .op_inc   (inc_en),
        .operand  (idu_opnd),
        .res_c    (idu_res),
        .idu_q    (idu_q),
        .idu_wrap (idu_wrap),
        .idu_zero (idu_zero)
    );

    // Per-register priority resolve; any enabled writer that owns nothing lost.
    always_comb begin
        src_e s;
        logic wa_won, wb_won, pw_won;
        wa_won = 1'b0;
        wb_won = 1'b0;
        pw_won = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            nxt[r] = regs[r];
            s      = SRC_NONE;
            if (idu_ok && idu_idx == PW'(r / 2)) begin
                nxt[r] = (r % 2 == 1) ? idu_res[DW-1:WIDTH] : idu_res[WIDTH-1:0];
                s      = SRC_IDU;
            end else if (pw_en && pw_idx == PW'(r / 2)) begin
                nxt[r] = (r % 2 == 1) ? pw_d[DW-1:WIDTH] : pw_d[WIDTH-1:0];
                s      = SRC_PW;
            end else if (wa_en && wa_idx == IW'(r)) begin
                nxt[r] = wa_d;
                s      = SRC_WA;
            end else if (wb_en && wb_idx == IW'(r)) begin
                nxt[r] = wb_d;
                s      = SRC_WB;
            end
            wa_won = wa_won | (s == SRC_WA);
            wb_won = wb_won | (s == SRC_WB);
            pw_won = pw_won | (s == SRC_PW);
        end
        conf_c = (wa_en & ~wa_won) | (wb_en & ~wb_won) | (pw_en & ~pw_won)
               | ((inc_en | dec_en) & ~idu_ok);
    end

    always_ff @(posedge CLK or negedge nres) begin
        if (!nres) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= RESET_VAL;
            wr_conf <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) regs[r] <= nxt[r];
            wr_conf <= conf_c;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [IW-1:0]    idx;
        logic [WIDTH-1:0] val;
        logic             hit;

        assign idx = rd_idx[k*IW +: IW];

        // Write-through reads look at the resolved next value instead of the flops.
        always_comb begin
            val = '0;
            hit = 1'b0;
            for (int r = 0; r < NREGS; r++) begin
                if (idx == IW'(r)) begin
                    val = BYPASS ? nxt[r] : regs[r];
                    hit = 1'b1;
                end
            end
        end

        assign rd_d[k*WIDTH +: WIDTH] = (rd_en[k] && hit) ? (INV_OUT ? ~val : val) : '0;
    end

endmodule

// File: tb/tb_regfile_pairs_gen.sv
// Scoreboard bench for regfile_pairs_gen: default instance plus a write-through instance.
module tb_regfile_pairs_gen;

    logic        CLK;
    logic        nres;
    logic        wa_en, wb_en, pw_en, inc_en, dec_en;
    logic [2:0]  wa_idx, wb_idx;
    logic [7:0]  wa_d, wb_d;
    logic [1:0]  pw_idx, idu_idx;
    logic [15:0] pw_d;
    logic [3:0]  rd_en;
    logic [11:0] rd_idx;
    logic [31:0] rd_d;
    logic [15:0] idu_q;
    logic        idu_wrap, idu_zero, wr_conf;

    logic        b_wa_en, b_wb_en, b_pw_en, b_inc_en, b_dec_en;
    logic [2:0]  b_wa_idx, b_wb_idx;
    logic [7:0]  b_wa_d, b_wb_d;
    logic [1:0]  b_pw_idx, b_idu_idx;
    logic [15:0] b_pw_d;
    logic [3:0]  b_rd_en;
    logic [11:0] b_rd_idx;
    logic [31:0] b_rd_d;
    logic [15:0] b_idu_q;
    logic        b_idu_wrap, b_idu_zero, b_wr_conf;

    regfile_pairs_gen dut (
        .CLK(CLK), .nres(nres),
        .wa_en(wa_en), .wa_idx(wa_idx), .wa_d(wa_d),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_d(wb_d),
        .pw_en(pw_en), .pw_idx(pw_idx), .pw_d(pw_d),
        .inc_en(inc_en), .dec_en(dec_en), .idu_idx(idu_idx),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_d(rd_d),
        .idu_q(idu_q), .idu_wrap(idu_wrap), .idu_zero(idu_zero), .wr_conf(wr_conf)
    );

    regfile_pairs_gen #(.BYPASS(1'b1)) dut_bp (
        .CLK(CLK), .nres(nres),
        .wa_en(b_wa_en), .wa_idx(b_wa_idx), .wa_d(b_wa_d),
        .wb_en(b_wb_en), .wb_idx(b_wb_idx), .wb_d(b_wb_d),
        .pw_en(b_pw_en), .pw_idx(b_pw_idx), .pw_d(b_pw_d),
        .inc_en(b_inc_en), .dec_en(b_dec_en), .idu_idx(b_idu_idx),
        .rd_en(b_rd_en), .rd_idx(b_rd_idx), .rd_d(b_rd_d),
        .idu_q(b_idu_q), .idu_wrap(b_idu_wrap), .idu_zero(b_idu_zero), .wr_conf(b_wr_conf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // kind: 0-3 rd port, 4 idu_q, 5 wrap, 6 zero, 7 wr_conf,
    // 8-11 bypass rd port, 12 b_wr_conf, 13 b_idu_q, 14 b_wrap, 15 b_zero
    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [15:0] actual(input int kind);
        if (kind < 4)        return {8'h00, rd_d[kind*8 +: 8]};
        else if (kind == 4)  return idu_q;
        else if (kind == 5)  return {15'd0, idu_wrap};
        else if (kind == 6)  return {15'd0, idu_zero};
        else if (kind == 7)  return {15'd0, wr_conf};
        else if (kind < 12)  return {8'h00, b_rd_d[(kind-8)*8 +: 8]};
        else if (kind == 12) return {15'd0, b_wr_conf};
        else if (kind == 13) return b_idu_q;
        else if (kind == 14) return {15'd0, b_idu_wrap};
        else                 return {15'd0, b_idu_zero};
    endfunction

    // Monitor: compare every expectation due by this cycle, mid-cycle.
    always @(negedge CLK) begin
        exp_t        e;
        logic [15:0] a;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            a = actual(e.kind);
            n_chk++;
            if (a === e.val) n_pass++;
            else $display("FAIL %s: got %h, expected %h (cycle %0d)", e.name, a, e.val, cyc);
        end
    end

    task automatic chk(input int kind, input logic [15:0] v, input string nm);
        exp_q.push_back('{cyc, kind, v, nm});
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
        wa_en = 1'b0; wb_en = 1'b0; pw_en = 1'b0; inc_en = 1'b0; dec_en = 1'b0;
        b_wa_en = 1'b0; b_wb_en = 1'b0;
    endtask

    task automatic set_rd(input logic [2:0] i0, i1, i2, i3);
        rd_idx = {i3, i2, i1, i0};
    endtask

    task automatic b_set_rd(input logic [2:0] i0, i1);
        b_rd_idx = {3'd0, 3'd0, i1, i0};
    endtask

    task automatic wa(input logic [2:0] i, input logic [7:0] d);
        wa_en = 1'b1; wa_idx = i; wa_d = d;
    endtask

    task automatic wb(input logic [2:0] i, input logic [7:0] d);
        wb_en = 1'b1; wb_idx = i; wb_d = d;
    endtask

    task automatic pw(input logic [1:0] i, input logic [15:0] d);
        pw_en = 1'b1; pw_idx = i; pw_d = d;
    endtask

    initial begin
        nres = 1'b1;
        wa_en = 0; wb_en = 0; pw_en = 0; inc_en = 0; dec_en = 0;
        wa_idx = 0; wb_idx = 0; wa_d = 0; wb_d = 0; pw_idx = 0; pw_d = 0; idu_idx = 0;
        rd_en = 4'hF; rd_idx = 0;
        b_wa_en = 0; b_wb_en = 0; b_pw_en = 0; b_inc_en = 0; b_dec_en = 0;
        b_wa_idx = 0; b_wb_idx = 0; b_wa_d = 0; b_wb_d = 0; b_pw_idx = 0; b_pw_d = 0;
        b_idu_idx = 0; b_rd_en = 4'b0011; b_rd_idx = 0;

        // Reset asserted mid-cycle: registers read back as ~0, status cleared.
        @(posedge CLK);
        #3;
        nres = 1'b0;
        set_rd(3'd0, 3'd1, 3'd2, 3'd3);
        #1;
        n_chk++;
        if (rd_d === 32'hFFFF_FFFF) n_pass++;
        else $display("FAIL reset_rd_now: got %h", rd_d);
        n_chk++;
        if (idu_q === 16'h0000) n_pass++;
        else $display("FAIL reset_idu_q_now: got %h", idu_q);
        n_chk++;
        if (idu_wrap === 1'b0 && idu_zero === 1'b0) n_pass++;
        else $display("FAIL reset_flags_now: wrap %b zero %b", idu_wrap, idu_zero);
        n_chk++;
        if (wr_conf === 1'b0) n_pass++;
        else $display("FAIL reset_conf_now: got %b", wr_conf);
        for (int k = 0; k < 4; k++) chk(k, 16'h00FF, "reset_rd");
        chk(4, 16'h0000, "reset_idu_q");
        chk(5, 16'h0000, "reset_wrap");
        chk(6, 16'h0000, "reset_zero");
        chk(7, 16'h0000, "reset_conf");
        chk(13, 16'h0000, "reset_b_idu_q");
        chk(14, 16'h0000, "reset_b_wrap");
        chk(15, 16'h0000, "reset_b_zero");

        // Two byte writes to different registers; write-through read of r0.
        next_cyc();
        nres = 1'b1;
        wa(3'd2, 8'h5A);
        wb(3'd3, 8'hA5);
        b_wa_en = 1'b1; b_wa_idx = 3'd0; b_wa_d = 8'h3C;
        b_set_rd(3'd0, 3'd0);
        chk(8, 16'h00C3, "bypass_same_cycle");

        next_cyc();
        set_rd(3'd2, 3'd3, 3'd0, 3'd0);
        chk(0, 16'h00A5, "wa_r2");
        chk(1, 16'h005A, "wb_r3");
        chk(7, 16'h0000, "no_conf_split");
        wa(3'd4, 8'h11);
        wb(3'd4, 8'h22);
        b_wa_en = 1'b1; b_wa_idx = 3'd1; b_wa_d = 8'h10;
        b_wb_en = 1'b1; b_wb_idx = 3'd1; b_wb_d = 8'h20;
        b_set_rd(3'd1, 3'd0);
        chk(8, 16'h00EF, "bypass_priority");
        chk(9, 16'h00C3, "bypass_held");

        // wa beats wb on r4.
        next_cyc();
        set_rd(3'd4, 3'd0, 3'd0, 3'd0);
        chk(0, 16'h00EE, "wa_beats_wb");
        chk(7, 16'h0001, "conf_pulse");
        chk(12, 16'h0001, "b_conf_pulse");
        pw(2'd1, 16'hFFFF);

        next_cyc();
        set_rd(3'd2, 3'd3, 3'd0, 3'd0);
        chk(0, 16'h0000, "pw_lo");
        chk(1, 16'h0000, "pw_hi");
        chk(7, 16'h0000, "conf_cleared");
        inc_en = 1'b1; idu_idx = 2'd1;

        // Increment from all-ones wraps to zero.
        next_cyc();
        chk(4, 16'h0000, "inc_wrap_q");
        chk(5, 16'h0001, "inc_wrap_flag");
        chk(6, 16'h0001, "inc_wrap_zero");
        chk(0, 16'h00FF, "inc_wrap_lo");
        chk(1, 16'h00FF, "inc_wrap_hi");
        chk(7, 16'h0000, "inc_no_conf");
        pw(2'd2, 16'h00FF);

        next_cyc();
        set_rd(3'd4, 3'd5, 3'd0, 3'd0);
        chk(0, 16'h0000, "pw2_lo");
        chk(1, 16'h00FF, "pw2_hi");
        chk(5, 16'h0000, "wrap_returns_0");
        chk(6, 16'h0001, "zero_holds");
        pw(2'd2, 16'h1234);
        inc_en = 1'b1; idu_idx = 2'd2;

        // IDU beats pair write, operand is the pre-edge 0x00FF.
        next_cyc();
        chk(0, 16'h00FF, "idu_beats_pw_lo");
        chk(1, 16'h00FE, "idu_beats_pw_hi");
        chk(7, 16'h0001, "idu_pw_conf");
        chk(4, 16'h0100, "idu_q_0100");
        chk(5, 16'h0000, "no_wrap_0100");
        chk(6, 16'h0000, "not_zero_0100");
        inc_en = 1'b1; dec_en = 1'b1; idu_idx = 2'd0;

        // inc and dec together: no-op with conflict.
        next_cyc();
        set_rd(3'd0, 3'd1, 3'd0, 3'd0);
        chk(7, 16'h0001, "incdec_conf");
        chk(4, 16'h0100, "incdec_q_holds");
        chk(0, 16'h00FF, "incdec_lo");
        chk(1, 16'h00FF, "incdec_hi");
        dec_en = 1'b1; idu_idx = 2'd0;

        // Decrement from zero wraps to all-ones; shared index and disabled port.
        next_cyc();
        rd_en = 4'b0111;
        chk(4, 16'hFFFF, "dec_wrap_q");
        chk(5, 16'h0001, "dec_wrap_flag");
        chk(6, 16'h0000, "dec_not_zero");
        chk(7, 16'h0000, "dec_no_conf");
        chk(0, 16'h0000, "dec_lo");
        chk(1, 16'h0000, "dec_hi");
        chk(2, 16'h0000, "shared_idx");
        chk(3, 16'h0000, "rd_disabled");

        // Reset during a pending write: write is discarded.
        next_cyc();
        rd_en = 4'hF;
        set_rd(3'd6, 3'd0, 3'd0, 3'd0);
        wa(3'd6, 8'h77);
        #1;
        nres = 1'b0;
        #1;
        chk(4, 16'h0000, "midreset_idu_q");
        chk(0, 16'h00FF, "midreset_r6");
        chk(1, 16'h00FF, "midreset_r0");

        next_cyc();
        nres = 1'b1;
        chk(0, 16'h00FF, "discarded_write");
        #1;
        n_chk++;
        if (rd_d[7:0] === 8'hFF) n_pass++;
        else $display("FAIL discarded_write_now: got %h", rd_d[7:0]);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) next_cyc();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_chk++;
            $display("FAIL %s: never compared, expected %h", e.name, e.val);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
